tdma_port_ctrl: RTL

TDMA_PORT_CTRL -- requirements
Module: tdma_port_ctrl

---
 rtl/tdma_port_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/tdma_port_ctrl.sv
// TDMA network port: TX FIFO drained one word per own slot, single-word RX holding register.
// Optional received-word drop counter is built when TDMA_DROP_CNT_EN is defined.
module tdma_port_ctrl #(
  parameter int NODE_ID    = 0,
  parameter int NUM_NODES  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [31:0] tx_data,
  input  logic [7:0]  tx_addr,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [31:0] net_data,
  output logic [7:0]  net_addr,
  output logic        net_valid,
  input  logic [31:0] rx_data,
  input  logic [7:0]  rx_addr,
  input  logic        rx_valid,
  output logic [31:0] recv_data,
  output logic        recv_valid,
  input  logic        recv_ack,
  output logic [7:0]  slot,
  output logic [7:0]  drop_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LAST_SLOT_I = NUM_NODES - 1;
  localparam logic [7:0] NODE_ADDR = NODE_ID[7:0];
  localparam logic [7:0] LAST_SLOT = LAST_SLOT_I[7:0];
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XMIT = 2'd2
  } tx_state_e;

  tx_state_e   state_q, state_d;
  logic [7:0]  slot_q, slot_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [31:0] net_data_q, net_data_d;
  logic [7:0]  net_addr_q, net_addr_d;
  logic        net_valid_q, net_valid_d;
  logic [31:0] recv_data_q, recv_data_d;
  logic        recv_valid_q, recv_valid_d;
  logic        push, pop, rx_accept, rx_capture;
  logic [39:0] fifo_mem [FIFO_DEPTH];

  // Slot counter, FIFO bookkeeping, TX FSM and link output staging.
  always_comb begin
    push        = tx_valid && (cnt_q != FULL_CNT);
    pop         = (state_q == ST_WAIT) && (slot_q == NODE_ADDR) && (cnt_q != '0);
    slot_d      = (slot_q == LAST_SLOT) ? 8'd0 : slot_q + 8'd1;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    net_valid_d = pop;
    net_data_d  = net_data_q;
    net_addr_d  = net_addr_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d   = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
      net_addr_d = fifo_mem[rd_ptr_q][39:32];
      net_data_d = fifo_mem[rd_ptr_q][31:0];
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + {{AW{1'b0}}, 1'b1};
      2'b01:   cnt_d = cnt_q - {{AW{1'b0}}, 1'b1};
      default: cnt_d = cnt_q;
    endcase

    // XMIT is the cycle the popped word is on the link; it re-arms on any word left or arriving.
    case (state_q)
      ST_IDLE: state_d = push ? ST_WAIT : ST_IDLE;
      ST_WAIT: state_d = pop ? ST_XMIT : ST_WAIT;
      ST_XMIT: state_d = (cnt_d != '0) ? ST_WAIT : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Receive holding register: capture when empty or being acknowledged this cycle.
  always_comb begin
    rx_accept  = rx_valid && ((rx_addr == NODE_ADDR) || (rx_addr == 8'hFF));
    rx_capture = rx_accept && (!recv_valid_q || recv_ack);
    if (rx_capture) begin
      recv_data_d  = rx_data;
      recv_valid_d = 1'b1;
    end else begin
      recv_data_d  = recv_data_q;
      recv_valid_d = recv_ack ? 1'b0 : recv_valid_q;
    end
  end

  // FIFO storage needs no reset: entries are read only while counted as occupied.
  always_ff @(posedge clk_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {tx_addr, tx_data};
    end
  end

  // State registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= ST_IDLE;
      slot_q       <= 8'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      net_data_q   <= 32'd0;
      net_addr_q   <= 8'd0;
      net_valid_q  <= 1'b0;
      recv_data_q  <= 32'd0;
      recv_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      net_data_q   <= net_data_d;
      net_addr_q   <= net_addr_d;
      net_valid_q  <= net_valid_d;
      recv_data_q  <= recv_data_d;
      recv_valid_q <= recv_valid_d;
    end
  end

`ifdef TDMA_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic       rx_drop;

  // Saturating count of accepted words lost to a full holding register.
  always_comb begin
    rx_drop = rx_accept && recv_valid_q && !recv_ack;
    if (rx_drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 8'd0;
`endif

  assign tx_ready   = (cnt_q != FULL_CNT);
  assign net_data   = net_data_q;
  assign net_addr   = net_addr_q;
  assign net_valid  = net_valid_q;
  assign recv_data  = recv_data_q;
  assign recv_valid = recv_valid_q;
  assign slot       = slot_q;

endmodule
